// File: rtl/fetch_stage.sv
// Fetch stage: PC, instruction-memory handshake, skid buffer and IF/ID register.
// Define FETCH_PERF_EN to add discard/wait performance counters.
module fetch_stage #(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] RESET_PC = 32'h0040_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_pc_keep,
    input  logic              i_IF_ID_keep,
    input  logic              i_IF_ID_flush,
    input  logic              i_branch_final,
    input  logic [DATA_W-1:0] i_branch_target,
    input  logic [1:0]        i_jump,
    input  logic [DATA_W-1:0] i_jump_target,
    input  logic [DATA_W-1:0] i_jr_target,
    output logic              o_imem_req,
    output logic [DATA_W-1:0] o_imem_addr,
    input  logic              i_imem_ready,
    input  logic [DATA_W-1:0] i_imem_rdata,
    output logic [DATA_W-1:0] o_IF_ID_instruction,
    output logic [DATA_W-1:0] o_IF_ID_pc_plus4,
`ifdef FETCH_PERF_EN
    output logic [31:0]       o_discard_count,
    output logic [31:0]       o_wait_count,
`endif
    output logic              o_IF_ID_valid
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_DROP  = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] buf_instr_q, buf_instr_d;
    logic [DATA_W-1:0] buf_pc4_q, buf_pc4_d;
    logic [DATA_W-1:0] ifid_instr_q, ifid_instr_d;
    logic [DATA_W-1:0] ifid_pc4_q, ifid_pc4_d;
    logic              ifid_valid_q, ifid_valid_d;

    logic              redirect;
    logic [DATA_W-1:0] target;
    logic              hold;
    logic              flush;
    logic [DATA_W-1:0] pc_plus4;
    logic              new_valid;
    logic [DATA_W-1:0] new_instr;
    logic [DATA_W-1:0] new_pc4;
    logic              discard;

    // Keep wins: a stalled PC ignores redirects and flushes this cycle.
    assign redirect = ~i_pc_keep &
                      (i_branch_final | (i_jump == 2'b01) | (i_jump == 2'b10));
    assign hold     = i_pc_keep | i_IF_ID_keep;
    assign flush    = i_IF_ID_flush & ~i_pc_keep;
    assign pc_plus4 = pc_q + DATA_W'(4);

    always_comb begin
        target = i_jr_target;
        if (i_branch_final) begin
            target = i_branch_target;
        end else if (i_jump == 2'b01) begin
            target = i_jump_target;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        addr_d      = addr_q;
        buf_instr_d = buf_instr_q;
        buf_pc4_d   = buf_pc4_q;
        new_valid   = 1'b0;
        new_instr   = '0;
        new_pc4     = '0;
        discard     = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                if (i_imem_ready) begin
                    if (redirect) begin
                        pc_d    = target;
                        discard = 1'b1;
                    end else if (!hold) begin
                        new_valid = 1'b1;
                        new_instr = i_imem_rdata;
                        new_pc4   = pc_plus4;
                        pc_d      = pc_plus4;
                    end else begin
                        buf_instr_d = i_imem_rdata;
                        buf_pc4_d   = pc_plus4;
                        pc_d        = pc_plus4;
                        state_d     = S_FULL;
                    end
                end else if (redirect) begin
                    // Old request stays on the bus until memory answers it.
                    addr_d  = pc_q;
                    pc_d    = target;
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (redirect) begin
                    pc_d = target;
                end
                if (i_imem_ready) begin
                    discard = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_FULL: begin
                if (redirect) begin
                    pc_d    = target;
                    discard = 1'b1;
                    state_d = S_FETCH;
                end else if (!hold) begin
                    new_valid = 1'b1;
                    new_instr = buf_instr_q;
                    new_pc4   = buf_pc4_q;
                    state_d   = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_comb begin
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        if (i_IF_ID_keep) begin
            ifid_valid_d = ifid_valid_q;
        end else if (flush || !new_valid) begin
            ifid_instr_d = '0;
            ifid_pc4_d   = '0;
            ifid_valid_d = 1'b0;
        end else begin
            ifid_instr_d = new_instr;
            ifid_pc4_d   = new_pc4;
            ifid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            addr_q       <= RESET_PC;
            buf_instr_q  <= '0;
            buf_pc4_q    <= '0;
            ifid_instr_q <= '0;
            ifid_pc4_q   <= '0;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            addr_q       <= addr_d;
            buf_instr_q  <= buf_instr_d;
            buf_pc4_q    <= buf_pc4_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    assign o_imem_req          = reset & (state_q != S_FULL);
    assign o_imem_addr         = (state_q == S_DROP) ? addr_q : pc_q;
    assign o_IF_ID_instruction = ifid_instr_q;
    assign o_IF_ID_pc_plus4    = ifid_pc4_q;
    assign o_IF_ID_valid       = ifid_valid_q;

`ifdef FETCH_PERF_EN
    logic [31:0] disc_cnt_q;
    logic [31:0] wait_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            disc_cnt_q <= '0;
            wait_cnt_q <= '0;
        end else begin
            if (discard && !(&disc_cnt_q)) begin
                disc_cnt_q <= disc_cnt_q + 32'd1;
            end
            if (o_imem_req && !i_imem_ready && !(&wait_cnt_q)) begin
                wait_cnt_q <= wait_cnt_q + 32'd1;
            end
        end
    end

    assign o_discard_count = disc_cnt_q;
    assign o_wait_count    = wait_cnt_q;
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Front end of the 5-stage pipeline: owns the PC, the instruction-memory request handshake and the IF/ID pipeline register.
- Consumes the keep/flush controls and redirect targets produced by the hazard and branch/jump logic. It is the receiving end of the stall/flush interface.
- Tolerates variable-latency instruction memory through a one-entry skid buffer and discard of stale responses.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset
- DATA_W, 32, instruction/address width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- i_pc_keep  in  1  hold PC; no new fetch issued
- i_IF_ID_keep  in  1  hold IF/ID register contents
- i_IF_ID_flush  in  1  load bubble into IF/ID
- i_branch_final  in  1  taken branch resolved in ID; redirect to i_branch_target
- i_branch_target  in  DATA_W  branch target
- i_jump  in  2  00 none, 01 j/jal (i_jump_target), 10 jr/jalr (i_jr_target), 11 treated as 00
- i_jump_target  in  DATA_W
- i_jr_target  in  DATA_W
- o_imem_req  out  1  fetch request
- o_imem_addr  out  DATA_W  fetch address, stable while req=1 and ready=0
- i_imem_ready  in  1  response valid this cycle
- i_imem_rdata  in  DATA_W  instruction
- o_IF_ID_instruction  out  DATA_W
- o_IF_ID_pc_plus4  out  DATA_W
- o_IF_ID_valid  out  1  0 = bubble

Behaviour:
- Reset values:
  - PC = RESET_PC; state = S_FETCH.
  - o_imem_req = 0 during reset, 1 in the first cycle after release.
  - o_imem_addr = RESET_PC.
  - o_IF_ID_instruction = 0, o_IF_ID_pc_plus4 = 0, o_IF_ID_valid = 0.
- Redirect = ~i_pc_keep & (i_branch_final | i_jump==01 | i_jump==10). Target priority: branch > jump > jr.
- Keep dominates: while i_pc_keep=1, redirect and flush are ignored. The jr/beq operand stall holds the jump in ID until the next cycle.
- IF/ID update, in priority order:
  - i_IF_ID_keep=1: hold.
  - i_IF_ID_flush=1: bubble (instr 0, valid 0).
  - New instruction available: load instruction, pc+4, valid=1.
  - Otherwise: bubble.
- States:
  - S_FETCH: req=1, addr=PC.
    - ready=1 & redirect: discard data; PC<=target; stay S_FETCH.
    - ready=1 & ~keep: deliver to IF/ID; PC<=PC+4.
    - ready=1 & keep: capture into buffer (instr, PC+4); PC<=PC+4; go S_FULL.
    - ready=0 & redirect: PC<=target; go S_DROP.
    - ready=0, no redirect: stay S_FETCH.
  - S_DROP: req=1 with the old address held in an address register.
    - On ready: discard data; go S_FETCH with the new PC.
    - A further redirect updates PC only.
  - S_FULL: req=0.
    - Redirect: discard buffer; PC<=target; go S_FETCH.
    - Else keep=0: deliver buffer to IF/ID; go S_FETCH.
- Latency:
  - Zero-wait memory (ready in the request cycle): one instruction per cycle; IF/ID valid on the edge after the request.
  - A redirect costs exactly one bubble.
- Address arithmetic: PC+4 is modulo 2^DATA_W; 32'hFFFF_FFFC+4 wraps to 0. No alignment check.
- Reset asserted mid-request: all state is cleared asynchronously; any response arriving after release is treated as fresh only if req was reasserted.

Optional Feature:
- FETCH_PERF_EN defined: adds outputs o_discard_count (32) and o_wait_count (32).
  - o_discard_count increments per dropped response or discarded buffer.
  - o_wait_count increments per cycle with req=1 & ready=0.
  - Both reset to 0 and saturate at 32'hFFFF_FFFF.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Zero-wait memory, no hazards, from reset -> addresses 0x00400000, 04, 08, … on consecutive cycles; IF/ID pc_plus4 0x00400004, 08, … with valid=1.
- i_pc_keep=i_IF_ID_keep=1 for 2 cycles at PC 0x00400008 with ready=1 -> one instruction buffered; req=0 while held; buffer delivered the cycle keep drops; no instruction lost or duplicated.
- i_branch_final=1, target 0x00400100 -> next IF/ID is a bubble (valid 0), then addr 0x00400100; in-flight data dropped.
- Memory with 3-cycle latency; i_jump=10, jr target 0x00400200 issued while waiting -> addr held at old value until ready; that response is discarded; then addr 0x00400200.
- i_pc_keep=1 together with i_jump=10 and i_IF_ID_flush=1 -> PC and IF/ID unchanged; redirect taken the cycle keep clears.
- reset driven low while in S_DROP -> outputs return to reset values immediately; first request after release uses RESET_PC; with FETCH_PERF_EN, counters read 0.
